uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter PARITY, default "NONE", parity mode: "NONE", "EVEN" or "ODD".
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame: 1 or 2.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 bd_rate  input  1  one-clk strobe per bit period (tx_bd_en from baud_rate_en).
REQ-006 tx_data  input  8  byte to send; sampled only on accept.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  block can accept a byte this cycle.
REQ-009 tx  output  1  serial line; idle high; registered.
REQ-010 tx_busy  output  1  frame in progress; high whenever state is not IDLE.
REQ-011 tx_done  output  1  one-clk pulse on the bd_rate that ends the final stop bit.

Function
REQ-012 Frame format SHALL be: start bit 0; 8 data bits, LSB first; optional parity bit; STOP_BITS stop bits of 1.
REQ-013 Each bit SHALL be held on tx from one bd_rate strobe to the next; tx changes only in the clk cycle following a strobe.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PAR, STOP and END.
REQ-015 An accept SHALL occur when tx_valid && tx_ready at posedge clk: tx_data is latched into the shift register and parity is computed from it.
REQ-016 tx_ready SHALL be 1 in IDLE and END, and 0 in all other states.
REQ-017 IDLE: tx=1. On accept -> START. A bd_rate in the accept cycle SHALL NOT emit the start bit.
REQ-018 START: on bd_rate -> tx<=0, bit counter<=0, go to DATA.
REQ-019 DATA: on bd_rate -> tx<=shreg[0], shift right, counter+1. After the 8th data bit the next strobe goes to PAR, or to STOP if PARITY="NONE".
REQ-020 PAR: on bd_rate -> tx<=^data for "EVEN", or ~^data for "ODD"; go to STOP.
REQ-021 STOP: on bd_rate -> tx<=1. After STOP_BITS stop bits have been emitted, go to END.
REQ-022 END: tx=1 (final stop bit in progress).
  - on bd_rate with no byte held: pulse tx_done, go to IDLE.
  - accept in END: go to START; tx_done still pulses on the ending strobe, and that same strobe emits the start bit, so back-to-back frames have no idle gap.
REQ-023 tx_valid and tx_data changes while tx_ready=0 SHALL be ignored; tx_data changes after accept SHALL not affect the frame in progress.
REQ-024 bd_rate SHALL be ignored in IDLE.
REQ-025 Strobe spacing SHALL be arbitrary, including back-to-back strobes.
REQ-026 Latency: accept-to-start-bit is the next bd_rate strobe after the accept cycle.
REQ-027 Frame length is 10 bit periods for NONE/1 stop and 12 for EVEN/2 stop.

Reset
REQ-028 While rst=1: state=IDLE, tx=1, tx_ready=0, tx_busy=0, tx_done=0, shift register and counters cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; no partial frame resumes.
REQ-030 tx_ready SHALL become 1 in the first clk cycle after rst deasserts.

Structure
REQ-031 Package uart_pkg SHALL hold:
  - the FSM state enum (shared style with rx);
  - parity mode constants;
  - the DATA_BITS=8 constant.
REQ-032 Single flat module with no sub-module; baud_rate_en is instantiated by the parent, not inside uart_tx.
REQ-033 An illegal PARITY or STOP_BITS value SHALL cause an elaboration error.

Verification
REQ-034 PARITY=NONE, accept 8'h66 -> tx per bit period: 0, 0,1,1,0,0,1,1,0, 1; then tx_done pulses once and tx_ready=1.
REQ-035 PARITY=EVEN, send 8'h66 then 8'h07 -> parity bits 0 and 1 respectively. PARITY=ODD, send 8'h66 -> parity bit 1.
REQ-036 Back-to-back 8'h55 then 8'hAA, with tx_valid held so the second is accepted during END -> exactly STOP_BITS high periods between frames, no idle gap.
REQ-037 Loopback into rx (PARITY="NONE") clocked by baud_rate_en -> rx_data=8'h66 with one rx_rdy pulse per frame, over 16 consecutive frames.
REQ-038 Assert rst during data bit 4 -> tx=1 that same cycle; after release, a new 8'hA5 transmits correctly.
REQ-039 tx_valid arrives in the same cycle as bd_rate in IDLE -> start bit appears only at the following strobe; tx_data changed after accept does not alter the frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame state encoding, parity mode names and the data width.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam string PARITY_NONE = "NONE";
    localparam string PARITY_EVEN = "EVEN";
    localparam string PARITY_ODD  = "ODD";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_END
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// with each bit advanced by an external one-clock bd_rate strobe.
module uart_tx
    import uart_pkg::*;
#(
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bd_rate,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam bit PAR_EN  = (PARITY != PARITY_NONE);
    localparam bit PAR_ODD = (PARITY == PARITY_ODD);
    localparam int CNT_W   = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    if (!(PARITY == PARITY_NONE || PARITY == PARITY_EVEN || PARITY == PARITY_ODD)) begin : g_bad_parity
        $error("uart_tx: PARITY must be \"NONE\", \"EVEN\" or \"ODD\"");
    end

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return PAR_ODD ? ~^d : ^d;
    endfunction

    uart_state_e            state, state_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   par_bit, par_nxt;
    logic                   tx_nxt;
    // Set when a byte was accepted in END before its closing strobe: that strobe,
    // taken in START, still owes the tx_done pulse of the previous frame.
    logic                   stop_pend, pend_nxt;
    logic                   accept;

    assign tx_ready = !rst && (state == ST_IDLE || state == ST_END);
    assign tx_busy  = (state != ST_IDLE);
    assign accept   = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            shreg     <= '0;
            cnt       <= '0;
            par_bit   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx        <= tx_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            par_bit   <= par_nxt;
            stop_pend <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = tx;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        par_nxt   = par_bit;
        pend_nxt  = stop_pend;
        tx_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (accept) begin
                    shreg_nxt = tx_data;
                    par_nxt   = parity_of(tx_data);
                    pend_nxt  = 1'b0;
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (bd_rate) begin
                    tx_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    tx_done   = stop_pend;
                    pend_nxt  = 1'b0;
                    state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bd_rate) begin
                    tx_nxt    = shreg[0];
                    shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
                    if (cnt == LAST_DATA) begin
                        cnt_nxt   = '0;
                        state_nxt = PAR_EN ? ST_PAR : ST_STOP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            ST_PAR: begin
                if (bd_rate) begin
                    tx_nxt    = par_bit;
                    state_nxt = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bd_rate) begin
                    tx_nxt = 1'b1;
                    if (cnt == LAST_STOP) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_END;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            ST_END: begin
                tx_done = bd_rate;
                // A byte taken on the closing strobe starts immediately, so frames abut.
                if (accept) begin
                    shreg_nxt = tx_data;
                    par_nxt   = parity_of(tx_data);
                    if (bd_rate) begin
                        tx_nxt    = 1'b0;
                        cnt_nxt   = '0;
                        pend_nxt  = 1'b0;
                        state_nxt = ST_DATA;
                    end else begin
                        pend_nxt  = 1'b1;
                        state_nxt = ST_START;
                    end
                end else if (bd_rate) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                tx_nxt    = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (NONE/1, EVEN/2, ODD/1) share clock, reset,
// strobe and data; each has its own tx_valid so scenarios drive one instance at a time.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bd_rate;
    logic [7:0] tx_data;
    logic       valid_n, valid_e, valid_o;
    logic       ready_n, tx_n, busy_n, done_n;
    logic       ready_e, tx_e, busy_e, done_e;
    logic       ready_o, tx_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt_n = 0;
    int done_cnt_e = 0;
    int done_cnt_o = 0;
    int acc_cnt_n  = 0;

    always #5 clk = ~clk;

    uart_tx #(.PARITY("NONE"), .STOP_BITS(1)) u_none (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(valid_n),
        .tx_ready(ready_n), .tx(tx_n), .tx_busy(busy_n), .tx_done(done_n)
    );

    uart_tx #(.PARITY("EVEN"), .STOP_BITS(2)) u_even (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(valid_e),
        .tx_ready(ready_e), .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e)
    );

    uart_tx #(.PARITY("ODD"), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(valid_o),
        .tx_ready(ready_o), .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o)
    );

    always @(posedge clk) begin
        if (done_n) done_cnt_n <= done_cnt_n + 1;
        if (done_e) done_cnt_e <= done_cnt_e + 1;
        if (done_o) done_cnt_o <= done_cnt_o + 1;
        if (valid_n && ready_n) acc_cnt_n <= acc_cnt_n + 1;
    end

    // One bd_rate strobe after 'gap' idle cycles; returns 1 time unit past the strobe edge.
    task automatic strobe(input int gap);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        bd_rate = 1'b1;
        @(posedge clk);
        #1;
        bd_rate = 1'b0;
    endtask

    task automatic load(input int which, input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        case (which)
            0:       valid_n = 1'b1;
            1:       valid_e = 1'b1;
            default: valid_o = 1'b1;
        endcase
        @(posedge clk);
        #1;
        valid_n = 1'b0;
        valid_e = 1'b0;
        valid_o = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bd_rate = 1'b0; tx_data = 8'h00;
        valid_n = 1'b0; valid_e = 1'b0; valid_o = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tx_n !== 1'b1)    begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx_n); end
        n_checks++; if (ready_n !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready_n); end
        n_checks++; if (busy_n !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_n); end
        n_checks++; if (done_n !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b want 0", done_n); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (ready_n !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready_none: got %b want 1", ready_n); end
        n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready_even: got %b want 1", ready_e); end
        strobe(0);
        strobe(0);
        n_checks++; if (tx_n !== 1'b1 || busy_n !== 1'b0)
            begin n_fail++; $display("FAIL idle_strobe_ignored: got tx=%b busy=%b want tx=1 busy=0", tx_n, busy_n); end
    endtask

    task automatic test_none_66;
        logic [9:0] frame;
        int d0;
        frame = {1'b1, 8'h66, 1'b0};
        d0 = done_cnt_n;
        load(0, 8'h66);
        n_checks++; if (tx_n !== 1'b1 || busy_n !== 1'b1 || ready_n !== 1'b0)
            begin n_fail++; $display("FAIL none_accept: got tx=%b busy=%b ready=%b want 1 1 0", tx_n, busy_n, ready_n); end
        for (int i = 0; i < 10; i++) begin
            strobe(0);
            n_checks++; if (tx_n !== frame[i]) begin n_fail++; $display("FAIL none66_bit%0d: got %b want %b", i, tx_n, frame[i]); end
            repeat (i % 3) @(posedge clk);
            #1;
            n_checks++; if (tx_n !== frame[i]) begin n_fail++; $display("FAIL none66_hold%0d: got %b want %b", i, tx_n, frame[i]); end
        end
        n_checks++; if (done_cnt_n !== d0) begin n_fail++; $display("FAIL none66_early_done: got %0d want %0d", done_cnt_n, d0); end
        strobe(0);
        n_checks++; if (done_cnt_n !== d0 + 1) begin n_fail++; $display("FAIL none66_done: got %0d want %0d", done_cnt_n, d0 + 1); end
        n_checks++; if (ready_n !== 1'b1 || busy_n !== 1'b0 || tx_n !== 1'b1)
            begin n_fail++; $display("FAIL none66_end: got ready=%b busy=%b tx=%b want 1 0 1", ready_n, busy_n, tx_n); end
    endtask

    task automatic test_parity_even(input logic [7:0] d, input logic par);
        logic [11:0] frame;
        int d0;
        frame = {2'b11, par, d, 1'b0};
        d0 = done_cnt_e;
        load(1, d);
        for (int i = 0; i < 12; i++) begin
            strobe(i % 2);
            n_checks++; if (tx_e !== frame[i]) begin n_fail++; $display("FAIL even_%h_bit%0d: got %b want %b", d, i, tx_e, frame[i]); end
        end
        n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL even_%h_end_ready: got %b want 1", d, ready_e); end
        strobe(0);
        n_checks++; if (done_cnt_e !== d0 + 1 || busy_e !== 1'b0)
            begin n_fail++; $display("FAIL even_%h_done: got cnt=%0d busy=%b want cnt=%0d busy=0", d, done_cnt_e, busy_e, d0 + 1); end
    endtask

    task automatic test_parity_odd;
        logic [10:0] frame;
        int d0;
        frame = {1'b1, 1'b1, 8'h66, 1'b0};
        d0 = done_cnt_o;
        load(2, 8'h66);
        for (int i = 0; i < 11; i++) begin
            strobe(0);
            n_checks++; if (tx_o !== frame[i]) begin n_fail++; $display("FAIL odd66_bit%0d: got %b want %b", i, tx_o, frame[i]); end
        end
        strobe(1);
        n_checks++; if (done_cnt_o !== d0 + 1) begin n_fail++; $display("FAIL odd66_done: got %0d want %0d", done_cnt_o, d0 + 1); end
    endtask

    task automatic test_back_to_back(input int which);
        logic [23:0] s;
        logic        txv;
        int          flen, d0;
        if (which == 0) begin
            flen = 10;
            s = {4'b0000, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
            d0 = done_cnt_n;
        end else begin
            flen = 12;
            s = {2'b11, 1'b0, 8'hAA, 1'b0, 2'b11, 1'b0, 8'h55, 1'b0};
            d0 = done_cnt_e;
        end
        @(negedge clk);
        tx_data = 8'h55;
        if (which == 0) valid_n = 1'b1; else valid_e = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hAA;
        for (int i = 0; i < 2 * flen; i++) begin
            strobe((i == flen && which == 0) ? 1 : 0);
            txv = (which == 0) ? tx_n : tx_e;
            n_checks++; if (txv !== s[i]) begin n_fail++; $display("FAIL b2b%0d_bit%0d: got %b want %b", which, i, txv, s[i]); end
            if (i == flen) begin
                valid_n = 1'b0;
                valid_e = 1'b0;
                n_checks++;
                if (((which == 0) ? done_cnt_n : done_cnt_e) !== d0 + 1)
                    begin n_fail++; $display("FAIL b2b%0d_first_done: got %0d want %0d", which, (which == 0) ? done_cnt_n : done_cnt_e, d0 + 1); end
            end
        end
        strobe(0);
        n_checks++;
        if (((which == 0) ? done_cnt_n : done_cnt_e) !== d0 + 2)
            begin n_fail++; $display("FAIL b2b%0d_done: got %0d want %0d", which, (which == 0) ? done_cnt_n : done_cnt_e, d0 + 2); end
    endtask

    task automatic test_loopback;
        logic [7:0] rx;
        int a0, d0, k;
        a0 = acc_cnt_n;
        d0 = done_cnt_n;
        k = 0;
        @(negedge clk);
        tx_data = 8'h66;
        valid_n = 1'b1;
        for (int f = 0; f < 16; f++) begin
            rx = 8'h00;
            strobe(k % 3); k++;
            if (acc_cnt_n == a0 + 16) valid_n = 1'b0;
            n_checks++; if (tx_n !== 1'b0) begin n_fail++; $display("FAIL loop_start%0d: got %b want 0", f, tx_n); end
            n_checks++; if (done_cnt_n !== d0 + f) begin n_fail++; $display("FAIL loop_done%0d: got %0d want %0d", f, done_cnt_n, d0 + f); end
            for (int b = 0; b < 8; b++) begin
                strobe(k % 3); k++;
                rx[b] = tx_n;
                if (acc_cnt_n == a0 + 16) valid_n = 1'b0;
            end
            strobe(k % 3); k++;
            if (acc_cnt_n == a0 + 16) valid_n = 1'b0;
            n_checks++; if (tx_n !== 1'b1) begin n_fail++; $display("FAIL loop_stop%0d: got %b want 1", f, tx_n); end
            n_checks++; if (rx !== 8'h66) begin n_fail++; $display("FAIL loop_data%0d: got %h want 66", f, rx); end
        end
        valid_n = 1'b0;
        strobe(0);
        n_checks++; if (done_cnt_n !== d0 + 16 || acc_cnt_n !== a0 + 16)
            begin n_fail++; $display("FAIL loop_totals: got done=%0d acc=%0d want %0d %0d", done_cnt_n - d0, acc_cnt_n - a0, 16, 16); end
    endtask

    task automatic test_idle_strobe_and_data_change;
        logic [9:0] frame;
        int a0, d0;
        frame = {1'b1, 8'h3C, 1'b0};
        a0 = acc_cnt_n;
        d0 = done_cnt_n;
        @(negedge clk);
        tx_data = 8'h3C; valid_n = 1'b1; bd_rate = 1'b1;
        @(posedge clk);
        #1;
        valid_n = 1'b0; bd_rate = 1'b0; tx_data = 8'hFF;
        n_checks++; if (tx_n !== 1'b1 || busy_n !== 1'b1)
            begin n_fail++; $display("FAIL accept_strobe_no_start: got tx=%b busy=%b want 1 1", tx_n, busy_n); end
        for (int i = 0; i < 10; i++) begin
            strobe(1);
            n_checks++; if (tx_n !== frame[i]) begin n_fail++; $display("FAIL chg3c_bit%0d: got %b want %b", i, tx_n, frame[i]); end
            if (i == 3) begin tx_data = 8'h00; valid_n = 1'b1; end
            if (i == 6) valid_n = 1'b0;
        end
        strobe(0);
        n_checks++; if (done_cnt_n !== d0 + 1 || acc_cnt_n !== a0 + 1)
            begin n_fail++; $display("FAIL chg3c_totals: got done=%0d acc=%0d want 1 1", done_cnt_n - d0, acc_cnt_n - a0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] frame;
        int d0;
        load(0, 8'h00);
        for (int i = 0; i < 6; i++) strobe(0);
        n_checks++; if (tx_n !== 1'b0) begin n_fail++; $display("FAIL mid_bit4: got %b want 0", tx_n); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (tx_n !== 1'b1 || busy_n !== 1'b0 || ready_n !== 1'b0)
            begin n_fail++; $display("FAIL mid_rst: got tx=%b busy=%b ready=%b want 1 0 0", tx_n, busy_n, ready_n); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        strobe(0);
        strobe(0);
        n_checks++; if (tx_n !== 1'b1 || busy_n !== 1'b0)
            begin n_fail++; $display("FAIL mid_no_resume: got tx=%b busy=%b want 1 0", tx_n, busy_n); end
        frame = {1'b1, 8'hA5, 1'b0};
        d0 = done_cnt_n;
        load(0, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            strobe(i % 2);
            n_checks++; if (tx_n !== frame[i]) begin n_fail++; $display("FAIL a5_bit%0d: got %b want %b", i, tx_n, frame[i]); end
        end
        strobe(0);
        n_checks++; if (done_cnt_n !== d0 + 1) begin n_fail++; $display("FAIL a5_done: got %0d want %0d", done_cnt_n, d0 + 1); end
    endtask

    initial begin
        test_reset();
        test_none_66();
        test_parity_even(8'h66, 1'b0);
        test_parity_even(8'h07, 1'b1);
        test_parity_odd();
        test_back_to_back(0);
        test_back_to_back(1);
        test_loopback();
        test_idle_strobe_and_data_change();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
